denoise_frame_driver: RTL and testbench
=======================================

// Module: denoise_frame_driver
// PURPOSE
//  Initiator that streams a thermal frame through the 3x3 noise-reduction accelerator.
//  For each interior pixel it reads the 9 neighbours from source frame RAM and writes
//  them to accelerator registers 1..9. It then reads the filtered result from register 0
//  and writes it to destination frame RAM.
//  Sits between the sensor frame buffer and the logging/output buffer; started by the host.
// PARAMETERS
//  IMG_W   32  frame width in pixels (>=3)
//  IMG_H   24  frame height in pixels (>=3)
//  ADDR_W  10  source/destination RAM address width (2^ADDR_W >= IMG_W*IMG_H)
// PORTS
//  clk            in   1       single clock; all logic rising-edge
//  reset          in   1       synchronous, active-high reset
//  start          in   1       begin frame; sampled only in IDLE
//  busy           out  1       high from cycle after accepted start until done cycle inclusive
//  done           out  1       one-cycle pulse after last destination write
//  src_addr       out  ADDR_W  source RAM word address
//  src_rd_en      out  1       source read strobe; src_rddata valid exactly 1 cycle later
//  src_rddata     in   32      source pixel
//  acc_addr       out  4       accelerator register address (0 = result, 1..9 = p1..p9)
//  acc_wr_en      out  1       accelerator write strobe
//  acc_rd_en      out  1       accelerator read strobe; acc_readdata valid same cycle
//  acc_writedata  out  32      pixel written to accelerator
//  acc_readdata   in   32      accelerator filtered sum
//  dst_addr       out  ADDR_W  destination RAM word address
//  dst_wr_en      out  1       destination write strobe
//  dst_wrdata     out  32      filtered pixel
// BEHAVIOUR
//  - Reset: state=IDLE. busy, done, all strobes, all addresses and all data outputs = 0.
//    Reset mid-frame aborts immediately; no partial writes are issued after reset.
//  - Outputs: one per centre (r,c), r=1..IMG_H-2, c=1..IMG_W-2, row-major.
//    dst_addr = (r-1)*(IMG_W-2)+(c-1); src address = row*IMG_W+col.
//  - Kernel order: k=0..8 = (r-1,c-1),(r-1,c),(r-1,c+1),(r,c-1),(r,c),(r,c+1),(r+1,c-1),
//    (r+1,c),(r+1,c+1). Element k goes to acc_addr=k+1.
//  - States: IDLE -> FETCH -> LOAD_LAST -> RESULT -> STORE -> (FETCH | DONE) -> IDLE.
//  - FETCH, 9 cycles, k=0..8: src_rd_en=1, src_addr=addr(k).
//    For k>=1, the same cycle also drives acc_wr_en=1, acc_addr=k and acc_writedata=src_rddata,
//    writing element k-1 as a one-stage pipeline.
//  - LOAD_LAST, 1 cycle: acc_wr_en=1, acc_addr=9, acc_writedata=src_rddata; src_rd_en=0.
//  - RESULT, 1 cycle: acc_rd_en=1, acc_addr=0; acc_readdata is registered into the result.
//  - STORE, 1 cycle: dst_wr_en=1, dst_addr=current, dst_wrdata=result.
//    The centre then advances: c++, wrapping to c=1 with r++ after c=IMG_W-2.
//    The last centre goes to DONE.
//  - DONE, 1 cycle: done=1, busy=1. Returns to IDLE with busy=0 next cycle.
//  - Latency: 12 cycles per output pixel. A full frame (defaults 30*22=660 outputs) takes
//    7920 cycles from the first FETCH. done asserts on the cycle after the last STORE.
//  - Strobes: acc_rd_en and acc_wr_en are never high together.
//    Strobes are 0 and data/addresses are held when not being driven.
//  - start: ignored while busy. If start is high in IDLE (including the cycle after DONE),
//    a new frame begins.
//  - Arithmetic: the result is passed through unmodified as a 32-bit value. Kernel gain is 100
//    (unnormalised), and overflow wraps modulo 2^32 exactly as the accelerator computes it.
//  - No back-pressure: source, accelerator and destination are always ready.
// TESTING
//  1. All-ones source, start pulse -> 660 dst writes each =100, addr 0..659 in order;
//     done exactly 7921 cycles after start.
//  2. Impulse src[5*32+5]=1, else 0 -> dst(4,4)=40; dst(3,4),(5,4),(4,3),(4,5)=10;
//     dst(3,3),(3,5),(5,3),(5,5)=5; all others 0.
//  3. Ramp src[i]=i -> dst at centre (r,c) = 100*(r*32+c), e.g. dst[0]=3300.
//  4. Hold start high through frame -> second start ignored until done; a new frame begins
//     in the IDLE cycle after done.
//  5. Assert reset for 1 cycle during frame at output 100 -> next cycle all outputs 0 and
//     busy=0. A fresh start rewrites from dst_addr 0.
//  6. Protocol monitor every frame -> rd/wr never concurrent. Each acc write k+1 carries the
//     src word read at addr(k) one cycle earlier.

Source files
------------

// File: rtl/denoise_frame_driver.sv
// Streams each interior pixel's 3x3 neighbourhood from the source frame RAM into the
// noise-reduction accelerator, then stores the filtered result in the destination RAM.

module denoise_frame_driver #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 24,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] src_addr,
  output logic              src_rd_en,
  input  logic [31:0]       src_rddata,
  output logic [3:0]        acc_addr,
  output logic              acc_wr_en,
  output logic              acc_rd_en,
  output logic [31:0]       acc_writedata,
  input  logic [31:0]       acc_readdata,
  output logic [ADDR_W-1:0] dst_addr,
  output logic              dst_wr_en,
  output logic [31:0]       dst_wrdata
);

  // state     | meaning
  // IDLE      | waiting for start, counters parked at the first centre
  // FETCH     | 9 source reads; reads k>=1 also push element k-1 to the accelerator
  // LOAD_LAST | push the ninth element to accelerator register 9
  // RESULT    | read filtered sum from accelerator register 0
  // STORE     | write result to destination, advance to the next centre
  // DONE      | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD_LAST,
    S_RESULT,
    S_STORE,
    S_DONE
  } state_t;

  localparam int COL_W = $clog2(IMG_W + 1);
  localparam logic [COL_W-1:0]  COL_FIRST = COL_W'(1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] ROW1      = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ROW2      = ADDR_W'(2 * IMG_W);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'((IMG_W - 2) * (IMG_H - 2) - 1);
  localparam logic [3:0]        K_LAST    = 4'd8;

  state_t              state_q, state_d;
  logic [3:0]          k_q;
  logic [COL_W-1:0]    col_q;
  logic [ADDR_W-1:0]   tl_q;
  logic [ADDR_W-1:0]   dst_idx_q;
  logic [31:0]         result_q;

  logic [ADDR_W-1:0]   src_addr_q;
  logic [3:0]          acc_addr_q;
  logic [31:0]         acc_wdata_q;
  logic [ADDR_W-1:0]   dst_addr_q;
  logic [31:0]         dst_wdata_q;

  // Offset of kernel element k from the top-left neighbour of the current centre.
  function automatic logic [ADDR_W-1:0] kernel_offset(input logic [3:0] k);
    logic [ADDR_W-1:0] off;
    case (k)
      4'd0:    off = '0;
      4'd1:    off = ADDR_W'(1);
      4'd2:    off = ADDR_W'(2);
      4'd3:    off = ROW1;
      4'd4:    off = ROW1 + ADDR_W'(1);
      4'd5:    off = ROW1 + ADDR_W'(2);
      4'd6:    off = ROW2;
      4'd7:    off = ROW2 + ADDR_W'(1);
      4'd8:    off = ROW2 + ADDR_W'(2);
      default: off = '0;
    endcase
    return off;
  endfunction

  always_comb begin
    state_d       = state_q;
    busy          = (state_q != S_IDLE);
    done          = 1'b0;
    src_rd_en     = 1'b0;
    acc_wr_en     = 1'b0;
    acc_rd_en     = 1'b0;
    dst_wr_en     = 1'b0;
    src_addr      = src_addr_q;
    acc_addr      = acc_addr_q;
    acc_writedata = acc_wdata_q;
    dst_addr      = dst_addr_q;
    dst_wrdata    = dst_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        src_rd_en = 1'b1;
        src_addr  = tl_q + kernel_offset(k_q);
        // Source data lags its read by one cycle, so read k lands element k-1.
        if (k_q != 4'd0) begin
          acc_wr_en     = 1'b1;
          acc_addr      = k_q;
          acc_writedata = src_rddata;
        end
        if (k_q == K_LAST) state_d = S_LOAD_LAST;
      end
      S_LOAD_LAST: begin
        acc_wr_en     = 1'b1;
        acc_addr      = 4'd9;
        acc_writedata = src_rddata;
        state_d       = S_RESULT;
      end
      S_RESULT: begin
        acc_rd_en = 1'b1;
        acc_addr  = 4'd0;
        state_d   = S_STORE;
      end
      S_STORE: begin
        dst_wr_en  = 1'b1;
        dst_addr   = dst_idx_q;
        dst_wrdata = result_q;
        state_d    = (dst_idx_q == LAST_IDX) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      col_q       <= COL_FIRST;
      tl_q        <= '0;
      dst_idx_q   <= '0;
      result_q    <= '0;
      src_addr_q  <= '0;
      acc_addr_q  <= '0;
      acc_wdata_q <= '0;
      dst_addr_q  <= '0;
      dst_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      src_addr_q  <= src_addr;
      acc_addr_q  <= acc_addr;
      acc_wdata_q <= acc_writedata;
      dst_addr_q  <= dst_addr;
      dst_wdata_q <= dst_wrdata;

      case (state_q)
        S_IDLE: begin
          k_q       <= '0;
          col_q     <= COL_FIRST;
          tl_q      <= '0;
          dst_idx_q <= '0;
        end
        S_FETCH: begin
          k_q <= (k_q == K_LAST) ? 4'd0 : k_q + 4'd1;
        end
        S_RESULT: begin
          result_q <= acc_readdata;
        end
        S_STORE: begin
          dst_idx_q <= dst_idx_q + ADDR_W'(1);
          // Wrapping a row skips the two border columns plus one step.
          if (col_q == COL_LAST) begin
            col_q <= COL_FIRST;
            tl_q  <= tl_q + ADDR_W'(3);
          end else begin
            col_q <= col_q + COL_W'(1);
            tl_q  <= tl_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_denoise_frame_driver.sv
// Self-checking bench: RAM and accelerator models, a protocol monitor, table-driven
// pixel checks and hand-written sequences for start-hold and mid-frame reset.

module tb_denoise_frame_driver;

  localparam int IMG_W     = 32;
  localparam int IMG_H     = 24;
  localparam int ADDR_W    = 10;
  localparam int OUT_W     = IMG_W - 2;
  localparam int OUT_N     = OUT_W * (IMG_H - 2);
  localparam int FRAME_CYC = 7921;

  logic              clk;
  logic              reset;
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] src_addr;
  logic              src_rd_en;
  logic [31:0]       src_rddata;
  logic [3:0]        acc_addr;
  logic              acc_wr_en;
  logic              acc_rd_en;
  logic [31:0]       acc_writedata;
  logic [31:0]       acc_readdata;
  logic [ADDR_W-1:0] dst_addr;
  logic              dst_wr_en;
  logic [31:0]       dst_wrdata;

  denoise_frame_driver #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .src_addr      (src_addr),
    .src_rd_en     (src_rd_en),
    .src_rddata    (src_rddata),
    .acc_addr      (acc_addr),
    .acc_wr_en     (acc_wr_en),
    .acc_rd_en     (acc_rd_en),
    .acc_writedata (acc_writedata),
    .acc_readdata  (acc_readdata),
    .dst_addr      (dst_addr),
    .dst_wr_en     (dst_wr_en),
    .dst_wrdata    (dst_wrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] src_mem [0:1023];
  logic [31:0] dst_mem [0:1023];
  logic [31:0] acc_p   [1:9];

  initial begin
    src_rddata = '0;
    for (int i = 1; i <= 9; i++) acc_p[i] = '0;
  end

  always @(posedge clk) begin
    if (src_rd_en) src_rddata <= src_mem[src_addr];
    if (acc_wr_en && acc_addr >= 4'd1 && acc_addr <= 4'd9) acc_p[acc_addr] <= acc_writedata;
    if (dst_wr_en) dst_mem[dst_addr] <= dst_wrdata;
  end

  // Accelerator: 5/10/40 weights, gain 100, wraps modulo 2^32.
  assign acc_readdata = 32'd5  * (acc_p[1] + acc_p[3] + acc_p[7] + acc_p[9])
                      + 32'd10 * (acc_p[2] + acc_p[4] + acc_p[6] + acc_p[8])
                      + 32'd40 * acc_p[5];

  int checks = 0;
  int errors = 0;

  int n_out        = 0;
  int frame_writes = 0;
  int wr_total     = 0;
  int ord_bad      = 0;
  int acc_bad      = 0;
  int rdwr_bad     = 0;
  logic              prev_rd   = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  function automatic int exp_src(input int n, input int k);
    int r, c;
    r = n / OUT_W + 1;
    c = n % OUT_W + 1;
    return (r - 1 + k / 3) * IMG_W + (c - 1 + k % 3);
  endfunction

  function automatic logic [31:0] exp_pix(input int pat, input int r, input int c);
    int dr, dc;
    logic [31:0] v;
    dr = r - 5;
    dc = c - 5;
    v = 32'd0;
    case (pat)
      0: v = 32'd100;
      1: begin
        if (dr >= -1 && dr <= 1 && dc >= -1 && dc <= 1) begin
          if (dr == 0 && dc == 0)      v = 32'd40;
          else if (dr == 0 || dc == 0) v = 32'd10;
          else                         v = 32'd5;
        end
      end
      default: v = 32'(100 * (r * IMG_W + c));
    endcase
    return v;
  endfunction

  // Protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      n_out   = 0;
      prev_rd = 1'b0;
    end else begin
      if (acc_rd_en && acc_wr_en) rdwr_bad++;
      if (acc_wr_en) begin
        int a;
        a = int'(acc_addr);
        if (a < 1 || a > 9 || !prev_rd || int'(prev_addr) != exp_src(n_out, a - 1) ||
            acc_writedata !== src_mem[prev_addr])
          acc_bad++;
      end
      if (dst_wr_en) begin
        if (int'(dst_addr) != n_out) ord_bad++;
        n_out++;
        wr_total++;
      end
      if (done) begin
        frame_writes = n_out;
        n_out        = 0;
      end
      prev_rd   = src_rd_en;
      prev_addr = src_addr;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_src(input int pat);
    for (int i = 0; i < 1024; i++) begin
      case (pat)
        0:       src_mem[i] = 32'd1;
        1:       src_mem[i] = (i == 5 * IMG_W + 5) ? 32'd1 : 32'd0;
        default: src_mem[i] = 32'(i);
      endcase
      dst_mem[i] = 32'hDEAD_BEEF;
    end
  endtask

  task automatic run_frame(output int cyc);
    start = 1'b1;
    cyc   = 0;
    for (int i = 0; i < 9000; i++) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
      end
      if (done) break;
    end
  endtask

  task automatic frame_checks(input int pat, input int cyc);
    int bad, first;
    chk($sformatf("done_latency_p%0d", pat), cyc, FRAME_CYC);
    tick();
    chk($sformatf("idle_after_done_p%0d", pat), {30'd0, busy, done}, 32'd0);
    chk($sformatf("frame_writes_p%0d", pat), frame_writes, OUT_N);
    chk($sformatf("dst_order_p%0d", pat), ord_bad, 0);
    chk($sformatf("acc_protocol_p%0d", pat), acc_bad, 0);
    chk($sformatf("rd_wr_overlap_p%0d", pat), rdwr_bad, 0);
    bad   = 0;
    first = -1;
    for (int r = 1; r <= IMG_H - 2; r++)
      for (int c = 1; c <= IMG_W - 2; c++)
        if (dst_mem[(r - 1) * OUT_W + (c - 1)] !== exp_pix(pat, r, c)) begin
          if (first < 0) first = (r - 1) * OUT_W + (c - 1);
          bad++;
        end
    chk($sformatf("frame_content_p%0d_first_bad_%0d", pat, first), bad, 0);
  endtask

  typedef struct {
    int          pat;
    int          r;
    int          c;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [19];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, wr_snap;

    // pattern 0 all-ones, 1 impulse at src(5,5), 2 ramp; (r,c) are centre coordinates
    vecs[0]  = '{0, 1, 1, 32'd100};
    vecs[1]  = '{0, 22, 30, 32'd100};
    vecs[2]  = '{0, 11, 15, 32'd100};
    vecs[3]  = '{1, 5, 5, 32'd40};
    vecs[4]  = '{1, 4, 5, 32'd10};
    vecs[5]  = '{1, 6, 5, 32'd10};
    vecs[6]  = '{1, 5, 4, 32'd10};
    vecs[7]  = '{1, 5, 6, 32'd10};
    vecs[8]  = '{1, 4, 4, 32'd5};
    vecs[9]  = '{1, 4, 6, 32'd5};
    vecs[10] = '{1, 6, 4, 32'd5};
    vecs[11] = '{1, 6, 6, 32'd5};
    vecs[12] = '{1, 3, 5, 32'd0};
    vecs[13] = '{1, 5, 7, 32'd0};
    vecs[14] = '{1, 1, 1, 32'd0};
    vecs[15] = '{2, 1, 1, 32'd3300};
    vecs[16] = '{2, 1, 30, 32'd6200};
    vecs[17] = '{2, 2, 1, 32'd6500};
    vecs[18] = '{2, 22, 30, 32'd73400};

    reset = 1'b1;
    start = 1'b0;
    load_src(0);
    repeat (3) tick();
    chk("reset_strobes", {26'd0, busy, done, src_rd_en, acc_wr_en, acc_rd_en, dst_wr_en}, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_strobes", {26'd0, busy, done, src_rd_en, acc_wr_en, acc_rd_en, dst_wr_en}, 32'd0);
    chk("idle_src_addr", {22'd0, src_addr}, 32'd0);
    chk("idle_acc_addr", {28'd0, acc_addr}, 32'd0);
    chk("idle_acc_wdata", acc_writedata, 32'd0);
    chk("idle_dst_addr", {22'd0, dst_addr}, 32'd0);
    chk("idle_dst_wdata", dst_wrdata, 32'd0);

    for (int p = 0; p < 3; p++) begin
      load_src(p);
      run_frame(cyc);
      frame_checks(p, cyc);
      foreach (vecs[v])
        if (vecs[v].pat == p)
          chk($sformatf("pix_p%0d_r%0d_c%0d", p, vecs[v].r, vecs[v].c),
              dst_mem[(vecs[v].r - 1) * OUT_W + (vecs[v].c - 1)], vecs[v].exp);
    end

    // start held high across a whole frame
    load_src(2);
    start = 1'b1;
    cyc   = 0;
    for (int i = 0; i < 9000; i++) begin
      tick();
      cyc++;
      if (done) break;
    end
    chk("hold_done_latency", cyc, FRAME_CYC);
    tick();
    chk("hold_idle_busy", {31'd0, busy}, 32'd0);
    chk("hold_frame_writes", frame_writes, OUT_N);
    tick();
    chk("hold_restart_busy", {31'd0, busy}, 32'd1);
    chk("hold_restart_rd", {31'd0, src_rd_en}, 32'd1);
    chk("hold_restart_addr", {22'd0, src_addr}, 32'd0);
    start = 1'b0;
    for (int i = 0; i < 1024; i++) dst_mem[i] = 32'hDEAD_BEEF;
    cyc = 1;
    for (int i = 0; i < 9000; i++) begin
      tick();
      cyc++;
      if (done) break;
    end
    frame_checks(2, cyc);

    // reset during output 100, then a fresh frame
    load_src(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (n_out == 100) break;
      tick();
    end
    chk("reached_output_100", n_out, 100);
    wr_snap = wr_total;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_strobes", {26'd0, busy, done, src_rd_en, acc_wr_en, acc_rd_en, dst_wr_en}, 32'd0);
    chk("abort_src_addr", {22'd0, src_addr}, 32'd0);
    chk("abort_acc_addr", {28'd0, acc_addr}, 32'd0);
    chk("abort_acc_wdata", acc_writedata, 32'd0);
    chk("abort_dst_addr", {22'd0, dst_addr}, 32'd0);
    chk("abort_dst_wdata", dst_wrdata, 32'd0);
    repeat (20) tick();
    chk("no_write_after_reset", wr_total - wr_snap, 32'd0);
    chk("abort_stays_idle", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 1024; i++) dst_mem[i] = 32'hDEAD_BEEF;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    for (int i = 0; i < 100; i++) begin
      if (dst_wr_en) break;
      tick();
      cyc++;
    end
    chk("fresh_first_cycle", cyc, 12);
    chk("fresh_first_addr", {22'd0, dst_addr}, 32'd0);
    chk("fresh_first_data", dst_wrdata, 32'd3300);
    for (int i = 0; i < 9000; i++) begin
      tick();
      cyc++;
      if (done) break;
    end
    frame_checks(2, cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
